// File: rtl/counter_job_pkg.sv
// Shared types and default widths for the counter job scheduler.
package counter_job_pkg;

   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned DEF_WIDTH   = 8;
   localparam int unsigned DEF_LEN_W   = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_COUNT,
      S_RESP
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the pointer and wraps.
module rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [31:0] w_pos;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_pos   = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         w_pos = (32'(i_ptr) + k) % N;
         if (!o_any && i_req[w_pos[IW-1:0]]) begin
            o_grant[w_pos[IW-1:0]] = 1'b1;
            o_idx                  = w_pos[IW-1:0];
            o_any                  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_job_scheduler.sv
// Time-shares one external load/enable counter between NUM_REQ requesters,
// returning (load + len) mod 2^WIDTH to the requester that issued the job.
module counter_job_scheduler
   import counter_job_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned LEN_W   = DEF_LEN_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_load,
   input  logic [NUM_REQ*LEN_W-1:0] req_len,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]         rsp_data,
   output logic                     ctr_set,
   output logic                     ctr_ena,
   output logic [WIDTH-1:0]         ctr_din,
   input  logic [WIDTH-1:0]         ctr_value,
   output logic                     busy
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_load;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_rem;
   logic [IDX_W-1:0]   r_id;
   logic [IDX_W-1:0]   r_last;

   logic [NUM_REQ-1:0] w_grant;
   logic [IDX_W-1:0]   w_idx;
   logic               w_any;
   logic [WIDTH-1:0]   w_sel_load;
   logic [LEN_W-1:0]   w_sel_len;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_last),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   always_comb begin
      w_sel_load = '0;
      w_sel_len  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_idx == IDX_W'(i)) begin
            w_sel_load = req_load[i*WIDTH +: WIDTH];
            w_sel_len  = req_len[i*LEN_W +: LEN_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_load  <= '0;
         r_len   <= '0;
         r_rem   <= '0;
         r_id    <= '0;
         r_last  <= IDX_W'(NUM_REQ - 1);
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_load <= w_sel_load;
                  r_len  <= w_sel_len;
                  r_id   <= w_idx;
                  r_last <= w_idx;
               end
            end
            S_LOAD:  r_rem <= r_len;
            S_COUNT: r_rem <= r_rem - LEN_W'(1);
            default: ;
         endcase
      end
   end

   // rsp_data passes ctr_value straight through: the counter already took
   // its last update on the edge that entered RESP.
   always_comb begin
      w_next    = r_state;
      req_ready = '0;
      rsp_valid = '0;
      rsp_data  = '0;
      ctr_set   = 1'b0;
      ctr_ena   = 1'b0;
      ctr_din   = '0;
      busy      = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy      = 1'b0;
            req_ready = w_grant;
            if (w_any) w_next = S_LOAD;
         end
         S_LOAD: begin
            ctr_set = 1'b1;
            ctr_din = r_load;
            w_next  = (r_len == '0) ? S_RESP : S_COUNT;
         end
         S_COUNT: begin
            ctr_ena = 1'b1;
            if (r_rem == LEN_W'(1)) w_next = S_RESP;
         end
         S_RESP: begin
            rsp_valid[r_id] = 1'b1;
            rsp_data        = ctr_value;
            w_next          = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_counter_job_scheduler.sv
// Bench for counter_job_scheduler: directed scenarios plus random traffic,
// checked cycle by cycle against a timeline model of job service.
module tb_counter_job_scheduler;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int LW = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_load;
   logic [N*LW-1:0]  req_len;
   logic [N-1:0]     rsp_valid;
   logic [W-1:0]     rsp_data;
   logic             ctr_set;
   logic             ctr_ena;
   logic [W-1:0]     ctr_din;
   logic [W-1:0]     ctr_q;
   logic             busy;

   always #5 clk = ~clk;

   counter_job_scheduler #(.NUM_REQ(N), .WIDTH(W), .LEN_W(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_load  (req_load),
      .req_len   (req_len),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .ctr_set   (ctr_set),
      .ctr_ena   (ctr_ena),
      .ctr_din   (ctr_din),
      .ctr_value (ctr_q),
      .busy      (busy)
   );

   // The shared counter instance the scheduler drives.
   always @(posedge clk) begin
      if (rst)          ctr_q <= '0;
      else if (ctr_set) ctr_q <= ctr_din;
      else if (ctr_ena) ctr_q <= ctr_q + 8'd1;
   end

   // Requester-side job registers.
   logic [N-1:0]  d_valid = '0;
   logic [W-1:0]  d_load [N];
   logic [LW-1:0] d_len  [N];

   always_comb begin
      req_valid = d_valid;
      req_load  = '0;
      req_len   = '0;
      for (int i = 0; i < N; i++) begin
         req_load[i*W +: W]   = d_load[i];
         req_len[i*LW +: LW]  = d_len[i];
      end
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Timeline model: an acceptance at cycle T fixes every later event of
   // the job from its length alone.
   int           t_acc, set_cyc, ena_lo, ena_hi, rsp_cyc, next_acc, m_last, m_id;
   logic [W-1:0] m_din, m_rsp;
   logic [N-1:0] acc_vec = '0;
   bit           m_on = 0;

   initial begin
      logic [N-1:0] exp_ready;
      int           w, len;
      forever begin
         @(negedge clk);
         cyc++;
         if (m_on) begin
            exp_ready = '0;
            w = -1;
            if (cyc >= next_acc) begin
               for (int k = 1; k <= N; k++) begin
                  if (w < 0 && d_valid[(m_last + k) % N]) w = (m_last + k) % N;
               end
            end
            if (w >= 0) exp_ready[w] = 1'b1;
            check_eq("ready", req_ready, exp_ready);
            check_eq("set",   ctr_set, cyc == set_cyc);
            check_eq("din",   ctr_din, (cyc == set_cyc) ? m_din : 8'd0);
            check_eq("ena",   ctr_ena, (cyc >= ena_lo) && (cyc <= ena_hi));
            check_eq("excl",  ctr_set & ctr_ena, 0);
            check_eq("busy",  busy, (cyc > t_acc) && (cyc < next_acc));
            check_eq("rspv",  rsp_valid, (cyc == rsp_cyc) ? (32'd1 << m_id) : 32'd0);
            if (cyc == rsp_cyc) check_eq("rspd", rsp_data, m_rsp);
            acc_vec = exp_ready;
            if (w >= 0) begin
               len      = int'(d_len[w]);
               t_acc    = cyc;
               m_din    = d_load[w];
               m_rsp    = W'(int'(d_load[w]) + len);
               m_id     = w;
               m_last   = w;
               set_cyc  = cyc + 1;
               ena_lo   = cyc + 2;
               ena_hi   = cyc + len + 1;
               rsp_cyc  = cyc + len + 2;
               next_acc = cyc + len + 3;
            end
         end
         if (rst) begin
            m_on     = 1;
            acc_vec  = '0;
            m_last   = N - 1;
            t_acc    = cyc;
            next_acc = cyc + 1;
            set_cyc  = -1;
            ena_lo   = -1;
            ena_hi   = -2;
            rsp_cyc  = -1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      d_valid = d_valid & ~acc_vec;
   endtask

   task automatic submit(input int i, input logic [W-1:0] ld, input logic [LW-1:0] ln);
      d_load[i]  = ld;
      d_len[i]   = ln;
      d_valid[i] = 1'b1;
   endtask

   task automatic wait_done(input int i);
      for (int b = 0; b < 400 && d_valid[i]; b++) tick();
      check_eq("accept_tmo", d_valid[i], 0);
   endtask

   task automatic settle();
      for (int b = 0; b < 400 && (cyc + 1 < next_acc); b++) tick();
      tick();
   endtask

   initial begin
      int acc_cnt;
      for (int i = 0; i < N; i++) begin
         d_load[i] = '0;
         d_len[i]  = '0;
      end
      repeat (3) tick();
      rst = 1'b0;

      // Basic job, wrap-around job, zero-length job.
      submit(0, 8'h10, 8'd5);  wait_done(0); settle();
      submit(2, 8'hFE, 8'd4);  wait_done(2); settle();
      submit(1, 8'h33, 8'd0);  wait_done(1); settle();

      // All requesters continuously valid with len 1.
      for (int i = 0; i < N; i++) submit(i, 8'(8'h20 + i), 8'd1);
      acc_cnt = 0;
      for (int b = 0; b < 100 && acc_cnt < 5; b++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (!d_valid[i]) begin
               acc_cnt++;
               submit(i, 8'(8'h40 + b), 8'd1);
            end
         end
      end
      d_valid = '0;
      settle();

      // Reset in the middle of a long job: the pointer returns to N-1.
      submit(2, 8'h80, 8'd10);
      wait_done(2);
      submit(3, 8'h90, 8'd2);
      for (int b = 0; b < 50 && (cyc + 1 != ena_lo + 3); b++) tick();
      check_eq("reach_count", cyc + 1, ena_lo + 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      submit(0, 8'hA0, 8'd3);
      wait_done(0); wait_done(3); settle();

      // Request raised while busy waits for the next idle cycle.
      submit(0, 8'h40, 8'd6);
      wait_done(0);
      tick(); tick();
      submit(1, 8'h55, 8'd3);
      wait_done(1); settle();

      // Random traffic with occasional withdrawals and mid-job resets.
      for (int c = 0; c < 2500; c++) begin
         tick();
         rst = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!d_valid[i]) begin
               if ($urandom_range(0, 3) == 0)
                  submit(i, 8'($urandom),
                         ($urandom_range(0, 15) == 0) ? 8'($urandom_range(200, 255))
                                                      : 8'($urandom_range(0, 12)));
            end else if ($urandom_range(0, 40) == 0) begin
               d_valid[i] = 1'b0;
            end
         end
         if (cyc + 1 >= ena_lo && cyc + 1 <= ena_hi && $urandom_range(0, 60) == 0)
            rst = 1'b1;
      end
      tick();
      rst = 1'b0;
      d_valid = '0;
      settle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/counter_job_scheduler.md
# counter_job_scheduler

Shares one 8-bit load/enable counter between `NUM_REQ` requesters. Each requester submits a job: a start value and a count length. The scheduler arbitrates round-robin, drives the counter's `set`/`ena`/`din` controls to load and advance it, and returns the final count to the issuing requester. It sits between client logic and a single counter instance, and is the only driver of that counter's control inputs.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 8: counter/data width.
- `LEN_W`, default 8: job length width.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high; shared with the counter instance.
- `req_valid`  in  NUM_REQ  per-requester job valid.
- `req_ready`  out  NUM_REQ  per-requester accept, at most one bit set.
- `req_load`  in  NUM_REQ*WIDTH  start value; slice i belongs to requester i.
- `req_len`  in  NUM_REQ*LEN_W  number of increment cycles; slice i belongs to requester i.
- `rsp_valid`  out  NUM_REQ  one-cycle, one-hot completion pulse.
- `rsp_data`  out  WIDTH  final counter value; valid only with `rsp_valid`.
- `ctr_set`  out  1  counter load strobe.
- `ctr_ena`  out  1  counter increment enable.
- `ctr_din`  out  WIDTH  counter load data.
- `ctr_value`  in  WIDTH  counter output, registered in the counter.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states and transitions:
  - IDLE: if any `req_valid` is set, pick winner w and assert `req_ready[w]` combinationally in the same cycle. Latch load, len and id, then go to LOAD.
  - LOAD: `ctr_set`=1 and `ctr_din`=latched load for exactly 1 cycle. If len==0, go to RESP; otherwise load `remaining`=len and go to COUNT.
  - COUNT: `ctr_ena`=1 and decrement `remaining` each cycle. Go to RESP when `remaining`==1.
  - RESP: `rsp_valid[id]`=1 and `rsp_data`=`ctr_value` for 1 cycle; no backpressure. Go to IDLE.
- Arbitration:
  - Round-robin; search starts at (last_grant+1) mod NUM_REQ.
  - `last_grant` updates only on acceptance.
  - Reset value of `last_grant` is NUM_REQ-1, so requester 0 has first priority.
- Handshake:
  - A job transfers on `req_valid[i] && req_ready[i]`.
  - A requester holds valid and its data stable until accepted.
  - `req_ready` is 0 in every state except IDLE.
  - A requester may drop valid before acceptance; the job is then not taken.
- Arithmetic: result = (load + len) mod 2^WIDTH. Wrap-around is allowed and not flagged.
- Invariant: `ctr_set` and `ctr_ena` are never high in the same cycle.
- Outside LOAD and COUNT, `ctr_set`=`ctr_ena`=0 and `ctr_din`=0.
- Reset, including mid-job:
  - State returns to IDLE and the in-flight job is dropped with no response.
  - All outputs go to 0, `busy`=0, `last_grant`=NUM_REQ-1.
  - The counter clears on the same `rst`.

## Timing
- Cycle numbering: acceptance cycle is T.
  - LOAD is at T+1.
  - COUNT spans T+2 .. T+len+1.
  - RESP is at T+len+2.
- For len==0: RESP at T+2.
- Next acceptance is no earlier than T+len+3, so the service period is len+3 cycles per job.
- `rsp_data` samples `ctr_value` in RESP. The counter updated on the edge ending the last LOAD/COUNT cycle, so no extra settle cycle is needed.
- `req_ready` depends combinationally on `req_valid` and state. No other output is combinational from inputs, except `rsp_data` passing through `ctr_value` in RESP.

## Structure
- Package `counter_job_pkg` holds:
  - the state enum (IDLE, LOAD, COUNT, RESP);
  - default widths as localparams.
- Sub-module `rr_arbiter`:
  - parameter N;
  - inputs: req vector, pointer;
  - outputs: one-hot grant, encoded index, any-grant flag.
- Top level contains the FSM, job latches and the `remaining` down-counter.

## Test plan
- Req0 load 0x10, len 5 → `req_ready[0]` at T; `ctr_set`/`ctr_din`=0x10 at T+1; `ctr_ena` at T+2..T+6; `rsp_valid`=4'b0001 with data 0x15 at T+7.
- Req2 load 0xFE, len 4 → `rsp_data`=0x02 (wrap); `rsp_valid`=4'b0100.
- Req1 load 0x33, len 0 → no `ctr_ena` cycles; `rsp_data`=0x33 at T+2.
- All four requesters hold valid continuously, len 1 each → grant order 0,1,2,3,0; acceptances 4 cycles apart.
- Assert `rst` for 1 cycle during COUNT of a len-10 job → next cycle all outputs 0, no `rsp_valid`; next job granted to req0 even though req3 is also valid.
- Req1 raises valid while busy and holds data → `req_ready[1]` stays 0 until the current RESP completes; accepted in the following IDLE with correct data.
